mdu: RTL and testbench
======================

Name: mdu

Overview:
- Multiply/divide unit for the P6 pipelined MIPS core. Sits in the EX stage alongside the combinational ALU.
- Executes mult/multu/div/divu over a fixed number of cycles, holds the HI/LO registers, and services mthi/mtlo writes and mfhi/mflo reads.
- Exposes `busy` so the hazard unit stalls any MDU instruction that arrives in EX while an operation is pending.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy duration for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- A  input  32  operand rs / write data for mthi/mtlo.
- B  input  32  operand rt.
- MDUOp  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- start  input  1  one-cycle qualifier: MDUOp is valid this cycle.
- rd_sel  input  1  read select: 0 = LO, 1 = HI.
- C  output  32  rd_sel ? HI : LO (combinational from registers).
- busy  output  1  operation pending.

Behaviour:
- Reset (reset = 0, asynchronous):
  - HI, LO, counter, and pending-result registers all cleared.
  - busy = 0, C = 0.
  - A reset mid-operation aborts the operation; no commit occurs after release.
- Start acceptance: a start is accepted only when start = 1 and busy = 0. A start while busy = 1 is ignored entirely: no restart and no HI/LO write.
- MULT (signed) / MULTU (unsigned):
  - At the accepting edge, latch the 64-bit product into the pending registers and load the counter with MULT_CYCLES.
  - The upper 32 bits go to HI and the lower 32 bits to LO at commit.
- DIV / DIVU (signed / unsigned):
  - At the accepting edge, latch the quotient (LO) and remainder (HI) into pending and load the counter with DIV_CYCLES.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - B = 0: the counter is still loaded and busy behaves normally, but the commit is suppressed and HI/LO keep their old values.
  - Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Counter and commit timing:
  - busy = (counter != 0). The counter decrements by 1 each edge while nonzero.
  - On the edge where the counter goes 1 → 0, pending is committed to HI/LO.
  - busy is high for exactly N cycles after the accepting edge. The new HI/LO values are visible on C in the first cycle with busy = 0.
- MTHI / MTLO:
  - When accepted (busy = 0), HI or LO is written with A at that edge; busy stays 0. No other state changes.
  - Ignored while busy (the hazard unit guarantees this does not occur in correct flow).
- NONE / reserved op with start = 1: no effect.
- Reads: C is purely combinational from HI/LO. It shows the old values throughout busy, and there is no forwarding of pending results.
- The ALU is unaffected. Both units see the same A/B; the MDU ignores them when start = 0.

Test Plan:
- Reset, then release → busy = 0, C = 0 for both rd_sel values.
- MULT with A = 0xFFFFFFFE (−2), B = 3 → busy high 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. The same operands with MULTU → HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV with A = −7 (0xFFFFFFF9), B = 2 → busy high 10 cycles; then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU with 7 / 2 → LO = 3, HI = 1.
- MTHI with A = 0x12345678 while idle → HI = 0x12345678 next cycle and busy stays 0. Then MULT 2×3 followed by a second start MULT 4×4 at cycle 2 of busy → the second start is ignored, HI = 0, LO = 6 after 5 cycles.
- DIV with B = 0 after MTLO 0xAAAA5555 → busy high 10 cycles; HI/LO unchanged.
- DIV started, then reset asserted at busy cycle 4 → busy and HI/LO go to 0 immediately; after release there is no late commit and busy stays 0.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit: fixed-latency mult/div with HI/LO registers, mthi/mtlo writes
// and a combinational HI/LO read port. busy stays high while a result is pending.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  input  logic        start,
  input  logic        rd_sel,
  output logic [31:0] C,
  output logic        busy
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } mdu_op_e;

  mdu_op_e          op;
  logic [31:0]      hi, lo;
  logic [31:0]      pend_hi, pend_lo;
  logic             pend_en;
  logic [CNT_W-1:0] cnt;

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg, b_zero;
  logic [31:0] mag_a, mag_b, div_bs, div_bu;
  logic [31:0] sq_mag, sr_mag, q_s, r_s, q_u, r_u;

  assign op   = mdu_op_e'(MDUOp);
  assign busy = (cnt != '0);
  assign C    = rd_sel ? hi : lo;

  // Signed division is done on magnitudes so that 0x80000000 / -1 wraps to 0x80000000
  // without relying on simulator behaviour for signed overflow.
  always_comb begin
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};
    a_neg  = A[31];
    b_neg  = B[31];
    b_zero = (B == '0);
    mag_a  = a_neg ? (~A + 32'd1) : A;
    mag_b  = b_neg ? (~B + 32'd1) : B;
    div_bs = b_zero ? 32'd1 : mag_b;
    div_bu = b_zero ? 32'd1 : B;
    sq_mag = mag_a / div_bs;
    sr_mag = mag_a % div_bs;
    q_s    = (a_neg ^ b_neg) ? (~sq_mag + 32'd1) : sq_mag;
    r_s    = a_neg ? (~sr_mag + 32'd1) : sr_mag;
    q_u    = A / div_bu;
    r_u    = A % div_bu;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_en <= 1'b0;
      cnt     <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1) && pend_en) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (start) begin
      case (op)
        OP_MULT: begin
          {pend_hi, pend_lo} <= prod_s;
          pend_en <= 1'b1;
          cnt     <= CNT_W'(MULT_CYCLES);
        end
        OP_MULTU: begin
          {pend_hi, pend_lo} <= prod_u;
          pend_en <= 1'b1;
          cnt     <= CNT_W'(MULT_CYCLES);
        end
        OP_DIV: begin
          pend_hi <= r_s;
          pend_lo <= q_s;
          pend_en <= !b_zero;
          cnt     <= CNT_W'(DIV_CYCLES);
        end
        OP_DIVU: begin
          pend_hi <= r_u;
          pend_lo <= q_u;
          pend_en <= !b_zero;
          cnt     <= CNT_W'(DIV_CYCLES);
        end
        OP_MTHI: hi <= A;
        OP_MTLO: lo <= A;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed plus randomized bench for mdu: expected HI/LO and busy length are queued at
// issue time and compared when busy drops.
module tb_mdu;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk, reset, start, rd_sel, busy;
  logic [31:0] A, B, C;
  logic [2:0]  MDUOp;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cyc;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] cur_hi, cur_lo;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDUOp(MDUOp),
    .start(start), .rd_sel(rd_sel), .C(C), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_both(output logic [31:0] h, output logic [31:0] l);
    rd_sel = 1'b0; #1 l = C;
    rd_sel = 1'b1; #1 h = C;
    rd_sel = 1'b0;
  endtask

  // Independent reference: 64-bit native arithmetic, truncating signed division.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint sa, sb, q, r, p;
    longint unsigned pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin p = sa * sb; return p; end
      3'd2: begin pu = {32'd0, a} * {32'd0, b}; return pu; end
      3'd3: begin
        if (b == 0) return {h, l};
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 0) return {h, l};
        return {a % b, a / b};
      end
      default: return {h, l};
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int unsigned cyc,
                       input string tag);
    exp_t e;
    e.hi = eh; e.lo = el; e.cyc = cyc; e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    MDUOp = op; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUOp = 3'd0;
  endtask

  // Called at the first negedge after the accepting edge; counts remaining busy cycles.
  task automatic wait_done(input int unsigned already);
    exp_t        e;
    int unsigned n;
    logic [31:0] h, l;
    e = sb.pop_front();
    n = already;
    read_both(h, l);
    check({e.tag, "_hold_hi"}, h, cur_hi);
    check({e.tag, "_hold_lo"}, l, cur_lo);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({e.tag, "_cycles"}, n, e.cyc);
    read_both(h, l);
    check({e.tag, "_hi"}, h, e.hi);
    check({e.tag, "_lo"}, l, e.lo);
    cur_hi = h; cur_lo = l;
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a, input string tag);
    logic [31:0] h, l;
    @(negedge clk);
    MDUOp = op; A = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUOp = 3'd0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    read_both(h, l);
    if (op == 3'd5) cur_hi = a; else if (op == 3'd6) cur_lo = a;
    check({tag, "_hi"}, h, cur_hi);
    check({tag, "_lo"}, l, cur_lo);
  endtask

  initial begin
    logic [31:0] h, l, ra, rb;
    logic [2:0]  rop;
    logic [63:0] m;
    start = 1'b0; rd_sel = 1'b0; A = '0; B = '0; MDUOp = 3'd0;
    reset = 1'b0;
    cur_hi = '0; cur_lo = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    read_both(h, l);
    check("reset_hi", h, 32'd0);
    check("reset_lo", l, 32'd0);

    issue(3'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, MC, "mult"); wait_done(0);
    issue(3'd2, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, MC, "multu"); wait_done(0);
    issue(3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DC, "div"); wait_done(0);
    issue(3'd4, 32'd7, 32'd2, 32'd1, 32'd3, DC, "divu"); wait_done(0);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, DC, "div_ovf"); wait_done(0);

    mt(3'd5, 32'h12345678, "mthi");

    // Second start lands on busy cycle 2 and must be dropped.
    issue(3'd1, 32'd2, 32'd3, 32'd0, 32'd6, MC, "mult_ign");
    @(negedge clk);
    MDUOp = 3'd1; A = 32'd4; B = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUOp = 3'd0;
    wait_done(2);

    mt(3'd6, 32'hAAAA5555, "mtlo");
    issue(3'd3, 32'd100, 32'd0, 32'd0, 32'hAAAA5555, DC, "div0"); wait_done(0);
    mt(3'd0, 32'hDEADBEEF, "none");
    mt(3'd7, 32'hCAFEF00D, "rsvd");

    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      m   = model(rop, ra, rb, cur_hi, cur_lo);
      issue(rop, ra, rb, m[63:32], m[31:0], (rop <= 3'd2) ? MC : DC, $sformatf("rand%0d", i));
      wait_done(0);
    end

    // Reset during busy cycle 4 of a divide: immediate clear, no late commit.
    issue(3'd4, 32'd1000, 32'd7, 32'd0, 32'd0, DC, "rst_div");
    void'(sb.pop_front());
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("rst_busy", {31'd0, busy}, 32'd0);
    read_both(h, l);
    check("rst_hi", h, 32'd0);
    check("rst_lo", l, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (DC + 3) @(negedge clk);
    check("rst_after_busy", {31'd0, busy}, 32'd0);
    read_both(h, l);
    check("rst_after_hi", h, 32'd0);
    check("rst_after_lo", l, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
